// File: rtl/silife_max7219.sv
// rtl/silife_max7219.sv - MAX7219 SPI refresh driver for the silife cell matrix (option macro: SILIFE_MAX7219_MIRROR_EN)
module silife_max7219 #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           enable,
    input  logic [3:0]                                     intensity,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] row_select,
    input  logic [WIDTH-1:0]                               cells,
    output logic                                           spi_cs,
    output logic                                           spi_clk,
    output logic                                           spi_do,
    output logic                                           busy
);

    localparam int RSW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [RSW-1:0] ROW_LAST   = RSW'(HEIGHT - 1);
    localparam logic [7:0]     SCAN_LIMIT = 8'(HEIGHT - 1);

    typedef enum logic [3:0] {
        INIT_LOAD,
        INIT_SHIFT,
        INIT_LATCH,
        IDLE,
        ROW_LOAD,
        ROW_SHIFT,
        ROW_LATCH,
        INT_LOAD,
        INT_SHIFT,
        INT_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      init_idx_q, init_idx_d;
    logic [3:0]      intensity_q, intensity_d;
    logic [RSW-1:0]  row_q, row_d;
    logic [15:0]     shift_q, shift_d;
    logic [DW-1:0]   div_q, div_d;
    logic [3:0]      bit_q, bit_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            do_q, do_d;
    logic            busy_q, busy_d;

    logic [7:0]      row_data;
    logic [15:0]     load_word;

    assign row_select = row_q;
    assign spi_cs     = cs_q;
    assign spi_clk    = sclk_q;
    assign spi_do     = do_q;
    assign busy       = busy_q;

    // Data byte of a row frame; optionally mirrored for reversed segment wiring
    always_comb begin
        row_data = '0;
`ifdef SILIFE_MAX7219_MIRROR_EN
        for (int i = 0; i < 8; i++) begin
            row_data[i] = cells[7 - i];
        end
`else
        row_data = cells[7:0];
`endif
    end

    // Frame word presented during the LOAD cycle of each frame type
    always_comb begin
        load_word = {8'h0A, 4'h0, intensity};
        if (state_q == INIT_LOAD) begin
            case (init_idx_q)
                3'd0:    load_word = 16'h0F00;
                3'd1:    load_word = 16'h0900;
                3'd2:    load_word = {8'h0B, SCAN_LIMIT};
                3'd3:    load_word = {8'h0A, 4'h0, intensity};
                default: load_word = 16'h0C01;
            endcase
        end else if (state_q == ROW_LOAD) begin
            load_word = {8'(row_q) + 8'd1, row_data};
        end
    end

    // Next-state logic: frame sequencing, bit timing and output generation
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        intensity_d = intensity_q;
        row_d       = row_q;
        shift_d     = shift_q;
        div_d       = div_q;
        bit_d       = bit_q;
        cs_d        = cs_q;
        sclk_d      = sclk_q;
        do_d        = do_q;

        case (state_q)
            INIT_LOAD, ROW_LOAD, INT_LOAD: begin
                shift_d = load_word;
                do_d    = load_word[15];
                cs_d    = 1'b0;
                sclk_d  = 1'b0;
                div_d   = '0;
                bit_d   = '0;
                if (state_q == INIT_LOAD) begin
                    state_d = INIT_SHIFT;
                    if (init_idx_q == 3'd3) begin
                        intensity_d = intensity;
                    end
                end else if (state_q == ROW_LOAD) begin
                    state_d = ROW_SHIFT;
                end else begin
                    state_d     = INT_SHIFT;
                    intensity_d = intensity;
                end
            end

            INIT_SHIFT, ROW_SHIFT, INT_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q != 4'd15) begin
                        bit_d   = bit_q + 4'd1;
                        sclk_d  = 1'b0;
                        do_d    = shift_q[14];
                        shift_d = {shift_q[14:0], 1'b0};
                    end else begin
                        sclk_d = 1'b0;
                        cs_d   = 1'b1;
                        do_d   = 1'b0;
                        if (state_q == INIT_SHIFT) begin
                            state_d = INIT_LATCH;
                        end else if (state_q == ROW_SHIFT) begin
                            state_d = ROW_LATCH;
                        end else begin
                            state_d = INT_LATCH;
                        end
                    end
                end
            end

            INIT_LATCH, ROW_LATCH, INT_LATCH: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (state_q == INIT_LATCH) begin
                        if (init_idx_q == 3'd4) begin
                            state_d = IDLE;
                        end else begin
                            init_idx_d = init_idx_q + 3'd1;
                            state_d    = INIT_LOAD;
                        end
                    end else if (state_q == ROW_LATCH) begin
                        // Advancing here gives the matrix a full cycle before LOAD samples cells
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            IDLE: begin
                if (intensity != intensity_q) begin
                    state_d = INT_LOAD;
                end else if (enable) begin
                    state_d = ROW_LOAD;
                end
            end

            default: begin
                state_d = INIT_LOAD;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_LOAD;
            init_idx_q  <= '0;
            intensity_q <= '0;
            row_q       <= '0;
            shift_q     <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            do_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            intensity_q <= intensity_d;
            row_q       <= row_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            do_q        <= do_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_silife_max7219.sv
// tb/tb_silife_max7219.sv - scoreboard bench for silife_max7219
`timescale 1ns/1ps
module tb_silife_max7219;

    localparam int H   = 8;
    localparam int CD  = 4;
    localparam int RSW = $clog2(H);

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [3:0]     intensity;
    logic [RSW-1:0] row_select;
    logic [7:0]     cells;
    logic           spi_cs;
    logic           spi_clk;
    logic           spi_do;
    logic           busy;

    logic [7:0]     mem [H];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    bit          abort_pending = 0;

    logic [3:0]  m_int;
    int          m_row;
    bit          in_frame;

    logic        mon_prev_cs = 1'b1;
    logic        mon_prev_sclk = 1'b0;
    logic [15:0] mon_word = '0;
    int          mon_nbits = 0;
    int          mon_low = 0;
    logic [RSW-1:0] mon_rs_prev = '0;
    int          mon_rs_stable = 0;
    int          mon_rs_at_fall = 0;
    logic [RSW-1:0] mon_rs_val = '0;

    always #5 clk = ~clk;

    assign cells = mem[row_select];

    silife_max7219 #(.WIDTH(8), .HEIGHT(H), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .intensity  (intensity),
        .row_select (row_select),
        .cells      (cells),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_do     (spi_do),
        .busy       (busy)
    );

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic frame_done();
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got %04h, required no frame", mon_word);
        end else begin
            e = exp_q.pop_front();
            if (mon_word !== e || mon_nbits != 16) begin
                errors++;
                $display("FAIL frame: got %04h (%0d bits), required %04h (16 bits)", mon_word, mon_nbits, e);
            end
            if (e[15:8] >= 8'd1 && e[15:8] <= 8'(H)) begin
                checks++;
                if (mon_rs_at_fall < 2) begin
                    errors++;
                    $display("FAIL row_select_setup: stable %0d cycles before shift, required >= 2", mon_rs_at_fall);
                end
                checks++;
                if (8'(mon_rs_val) + 8'd1 != e[15:8]) begin
                    errors++;
                    $display("FAIL row_select_value: got %0d, required %0d", mon_rs_val, e[15:8] - 8'd1);
                end
            end
        end
        checks++;
        if (mon_low != 32 * CD) begin
            errors++;
            $display("FAIL cs_low_cycles: got %0d, required %0d", mon_low, 32 * CD);
        end
    endtask

    // Monitor: decodes frames on spi_clk rising edges, pops the scoreboard at each frame end
    initial begin
        forever begin
            @(negedge clk);
            if (row_select != mon_rs_prev) mon_rs_stable = 0;
            else mon_rs_stable++;
            mon_rs_prev = row_select;
            if (spi_clk === 1'b1 && mon_prev_sclk === 1'b0) begin
                if (spi_cs !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL sclk_rise_while_cs_high: spi_cs=%b, required 0", spi_cs);
                end else begin
                    mon_word = {mon_word[14:0], spi_do};
                    mon_nbits++;
                end
            end
            if (spi_cs === 1'b0 && mon_prev_cs === 1'b1) begin
                mon_word       = '0;
                mon_nbits      = 0;
                mon_low        = 0;
                mon_rs_at_fall = mon_rs_stable;
                mon_rs_val     = row_select;
            end
            if (spi_cs === 1'b0) mon_low++;
            if (spi_cs === 1'b1 && mon_prev_cs === 1'b0) begin
                if (abort_pending) abort_pending = 0;
                else frame_done();
            end
            mon_prev_cs   = spi_cs;
            mon_prev_sclk = spi_clk;
        end
    end

    task automatic wait_cs(input logic lvl, input int budget, input string tag, output int n);
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (spi_cs !== lvl && n < budget);
        if (spi_cs !== lvl) begin
            errors++;
            $display("FAIL %s: spi_cs=%b after %0d cycles, required %b", tag, spi_cs, n, lvl);
        end
    endtask

    // Reference model: decision taken in IDLE after the frame in progress
    task automatic predict(output bit has);
        logic [7:0] d;
        has = 1'b1;
        if (intensity != m_int) begin
            exp_q.push_back({8'h0A, 4'h0, intensity});
            m_int = intensity;
        end else if (enable) begin
            d = mem[m_row];
`ifdef SILIFE_MAX7219_MIRROR_EN
            d = {<<{d}};
`endif
            exp_q.push_back({8'(m_row + 1), d});
            m_row = (m_row + 1) % H;
        end else begin
            has = 1'b0;
        end
    endtask

    task automatic mutate(input int code);
        if (code == 1) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            mem[row_select] = 8'($urandom);
            if ($urandom_range(0, 99) < 35) begin
                intensity = 4'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                    intensity = 4'($urandom);
                end
            end
            enable = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(0, 2)) mem[$urandom_range(0, H - 1)] = 8'($urandom);
        end else if (code == 2) begin
            repeat (20) @(negedge clk);
            intensity = 4'h9;
        end else if (code == 3) begin
            repeat (30) @(negedge clk);
            enable = 1'b0;
        end
    endtask

    task automatic step(input int code);
        bit has;
        int n;
        mutate(code);
        predict(has);
        wait_cs(1'b1, 40 * CD, "frame_end", n);
        if (has) wait_cs(1'b0, 4 * CD + 8, "frame_start", n);
        in_frame = has;
    endtask

    task automatic idle_check(input int ncyc);
        int n = 0;
        bit bad = 0;
        while (busy !== 1'b0 && n < 4 * CD + 8) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_falls_in_idle", busy, 0);
        repeat (ncyc) begin
            @(negedge clk);
            if (spi_cs !== 1'b1 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_hold: spi_cs/busy left 1/0 during %0d idle cycles, required steady", ncyc);
        end
    endtask

    task automatic idle_wake(input int code);
        bit has;
        int n;
        idle_check($urandom_range(5, 30));
        enable = 1'b1;
        if (code == 1 && $urandom_range(0, 1) == 1) intensity = 4'($urandom);
        predict(has);
        wait_cs(1'b0, 4 * CD + 8, "wake_start", n);
        in_frame = has;
    endtask

    task automatic run_init();
        int n1, n2;
        bit bad = 0;
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0900);
        exp_q.push_back({8'h0B, 8'(H - 1)});
        exp_q.push_back({8'h0A, 4'h0, intensity});
        exp_q.push_back(16'h0C01);
        m_int = intensity;
        m_row = 0;
        wait_cs(1'b0, 8 * CD, "init_start", n1);
        repeat (4) begin
            wait_cs(1'b1, 40 * CD, "init_end", n1);
            wait_cs(1'b0, 4 * CD + 8, "init_next", n2);
            if (n1 + n2 != 1 + 33 * CD) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL init_frame_period: last got %0d cycles, required %0d", n1 + n2, 1 + 33 * CD);
        end
        in_frame = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        intensity = 4'h3;
        for (int r = 0; r < H; r++) mem[r] = 8'hA0 | 8'(r);
        repeat (3) @(negedge clk);
        check_val("reset_cs", spi_cs, 1);
        check_val("reset_sclk", spi_clk, 0);
        check_val("reset_do", spi_do, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_row_select", row_select, 0);
        reset = 1'b0;

        run_init();
        step(0);
        idle_wake(0);
        repeat (9) step(0);
        step(0);
        step(2);
        repeat (3) step(0);
        step(3);
        idle_wake(0);

        repeat (7 * 2 * CD + 2) @(negedge clk);
        reset = 1'b1;
        abort_pending = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_val("midframe_reset_cs", spi_cs, 1);
        check_val("midframe_reset_sclk", spi_clk, 0);
        reset = 1'b0;
        run_init();

        repeat (50) begin
            if (in_frame) step(1);
            else idle_wake(1);
        end

        repeat (3) begin
            if (in_frame) step(3);
        end
        idle_check(10);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
